// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus an iterative shift-add multiplier.
// Define ALU_DIV_EN to compile in the iterative restoring divider for opcode 1011.
module alu_multicycle #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             control,
    input  logic [WORD_LENGTH-1:0] dataA,
    input  logic [WORD_LENGTH-1:0] dataB,
    output logic                   busy,
    output logic                   done,
    output logic [WORD_LENGTH-1:0] dataC,
    output logic [WORD_LENGTH-1:0] dataHi,
    output logic                   carry,
    output logic                   zero
);

    localparam int W  = WORD_LENGTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [W-1:0]  W_VAL = W'(W);
    localparam logic [CW-1:0] LAST  = CW'(W - 1);

    localparam logic [3:0] OP_MUL = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_NOT = 4'b0011;
    localparam logic [3:0] OP_NEG = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_B4  = 4'b1010;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIV = 4'b1011;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    b_r;
    logic [W-1:0]    hi_r;
    logic [W-1:0]    lo_r;
    logic [W-1:0]    step_hi;
    logic [W-1:0]    step_lo;
    logic [W:0]      mul_sum;
    logic [W:0]      comb_res;
`ifdef ALU_DIV_EN
    logic            div_r;
    logic [W:0]      rem_sh;
    logic [W-1:0]    rem_diff;
`endif

    function automatic logic is_iter(input logic [3:0] op);
`ifdef ALU_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return (op == OP_MUL);
`endif
    endfunction

    // Single-cycle ops; result is {carry, dataC}.
    function automatic logic [W:0] alu_comb(input logic [3:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W:0] r;
        r = '0;
        case (op)
            OP_SUB: r = (a < b) ? {1'b1, b - a} : {1'b0, a - b};
            OP_ADD: r = {1'b0, a} + {1'b0, b};
            OP_NOT: r = {1'b0, ~a};
            OP_NEG: r = {1'b0, ~a + 1'b1};
            OP_AND: r = {1'b0, a & b};
            OP_OR:  r = {1'b0, a | b};
            OP_XOR: r = {1'b0, a ^ b};
            OP_SHL: r = (b >= W_VAL) ? '0 : {1'b0, a << b};
            OP_SHR: r = (b >= W_VAL) ? '0 : {1'b0, a >> b};
            OP_B4:  r = {1'b0, b << 2} + (W + 1)'(4);
            default: r = '0;
        endcase
        return r;
    endfunction

    assign comb_res = alu_comb(control, dataA, dataB);
    assign mul_sum  = {1'b0, hi_r} + {1'b0, b_r};

`ifdef ALU_DIV_EN
    assign rem_sh   = {hi_r, lo_r[W-1]};
    assign rem_diff = rem_sh[W-1:0] - b_r;
`endif

    // One iteration: hi_r:lo_r is product accumulator (MUL) or remainder:quotient (DIV).
    always_comb begin
        step_hi = {1'b0, hi_r[W-1:1]};
        step_lo = {hi_r[0], lo_r[W-1:1]};
        if (lo_r[0]) begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], lo_r[W-1:1]};
        end
`ifdef ALU_DIV_EN
        if (div_r) begin
            if (rem_sh >= {1'b0, b_r}) begin
                step_hi = rem_diff;
                step_lo = {lo_r[W-2:0], 1'b1};
            end else begin
                step_hi = rem_sh[W-1:0];
                step_lo = {lo_r[W-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = is_iter(control) ? CALC : DONE;
            CALC:    if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            dataC  <= '0;
            dataHi <= '0;
            carry  <= 1'b0;
            zero   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (start) begin
                    b_r  <= dataB;
                    hi_r <= '0;
                    lo_r <= dataA;
                    cnt  <= '0;
`ifdef ALU_DIV_EN
                    div_r <= (control == OP_DIV);
`endif
                    if (!is_iter(control)) begin
                        dataC  <= comb_res[W-1:0];
                        dataHi <= '0;
                        carry  <= comb_res[W];
                        zero   <= (comb_res[W-1:0] == '0);
                    end
                end
                CALC: begin
                    hi_r <= step_hi;
                    lo_r <= step_lo;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        dataC  <= step_lo;
                        dataHi <= step_hi;
                        zero   <= (step_lo == '0);
`ifdef ALU_DIV_EN
                        carry  <= div_r && (b_r == '0);
`else
                        carry  <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WORD_LENGTH=8.
// Expected values are hand-computed; the divide checks follow ALU_DIV_EN.
module tb_alu_multicycle;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] control;
    logic [7:0] dataA, dataB;
    logic       busy, done, carry, zero;
    logic [7:0] dataC, dataHi;

    int checks = 0;
    int errors = 0;

    alu_multicycle #(.WORD_LENGTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .control(control),
        .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
        .dataC(dataC), .dataHi(dataHi), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [7:0] c, input logic [7:0] hi,
                             input logic cy, input logic z);
        check({tag, "_c"}, 64'(dataC), 64'(c));
        check({tag, "_hi"}, 64'(dataHi), 64'(hi));
        check({tag, "_carry"}, 64'(carry), 64'(cy));
        check({tag, "_zero"}, 64'(zero), 64'(z));
    endtask

    // Issue one op in IDLE, wait for done, check latency and busy cycles; returns at the done cycle.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int lat);
        int n;
        int bc;
        @(negedge clk);
        control = op; dataA = a; dataB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        bc = busy ? 1 : 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_busy"}, 64'(bc), 64'(lat));
    endtask

    initial begin
        int dcount;
        reset = 1'b0; start = 1'b0; control = 4'h0; dataA = 8'h0; dataB = 8'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check_res("rst", 8'h00, 8'h00, 1'b0, 1'b1);
        reset = 1'b1;

        do_op("mul", 4'b0000, 8'd200, 8'd3, 9);
        check_res("mul", 8'h58, 8'h02, 1'b0, 1'b0);

        // Result held with no further start
        repeat (4) @(negedge clk);
        check("hold_done", 64'(done), 64'd0);
        check_res("hold", 8'h58, 8'h02, 1'b0, 1'b0);

        do_op("add", 4'b0010, 8'hFF, 8'h01, 1);
        check_res("add", 8'h00, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        check("add_done_pulse", 64'(done), 64'd0);

        do_op("sub_lt", 4'b0001, 8'd3, 8'd5, 1);
        check_res("sub_lt", 8'd2, 8'h00, 1'b1, 1'b0);
        do_op("sub_eq", 4'b0001, 8'd5, 8'd5, 1);
        check_res("sub_eq", 8'd0, 8'h00, 1'b0, 1'b1);
        do_op("sub_gt", 4'b0001, 8'd9, 8'd4, 1);
        check_res("sub_gt", 8'd5, 8'h00, 1'b0, 1'b0);
        do_op("not", 4'b0011, 8'h0F, 8'h00, 1);
        check_res("not", 8'hF0, 8'h00, 1'b0, 1'b0);
        do_op("neg", 4'b0100, 8'h01, 8'h00, 1);
        check_res("neg", 8'hFF, 8'h00, 1'b0, 1'b0);
        do_op("and", 4'b0101, 8'hA5, 8'h0F, 1);
        check_res("and", 8'h05, 8'h00, 1'b0, 1'b0);
        do_op("or", 4'b0110, 8'hA0, 8'h05, 1);
        check_res("or", 8'hA5, 8'h00, 1'b0, 1'b0);
        do_op("xor", 4'b0111, 8'hFF, 8'h0F, 1);
        check_res("xor", 8'hF0, 8'h00, 1'b0, 1'b0);
        do_op("shl1", 4'b1000, 8'h81, 8'd1, 1);
        check_res("shl1", 8'h02, 8'h00, 1'b0, 1'b0);
        do_op("shl8", 4'b1000, 8'h81, 8'd8, 1);
        check_res("shl8", 8'h00, 8'h00, 1'b0, 1'b1);
        do_op("shr3", 4'b1001, 8'h81, 8'd3, 1);
        check_res("shr3", 8'h10, 8'h00, 1'b0, 1'b0);
        do_op("shr200", 4'b1001, 8'h81, 8'd200, 1);
        check_res("shr200", 8'h00, 8'h00, 1'b0, 1'b1);
        do_op("b4_ovf", 4'b1010, 8'h00, 8'h3F, 1);
        check_res("b4_ovf", 8'h00, 8'h00, 1'b1, 1'b1);
        do_op("undef", 4'b1111, 8'h12, 8'h34, 1);
        check_res("undef", 8'h00, 8'h00, 1'b0, 1'b1);
        do_op("b4", 4'b1010, 8'h00, 8'h10, 1);
        check_res("b4", 8'h44, 8'h00, 1'b0, 1'b0);

        do_op("mul_max", 4'b0000, 8'hFF, 8'hFF, 9);
        check_res("mul_max", 8'h01, 8'hFE, 1'b0, 1'b0);

`ifdef ALU_DIV_EN
        do_op("div", 4'b1011, 8'd100, 8'd7, 9);
        check_res("div", 8'd14, 8'd2, 1'b0, 1'b0);
        do_op("div0", 4'b1011, 8'd100, 8'd0, 9);
        check_res("div0", 8'hFF, 8'd100, 1'b1, 1'b0);
`else
        do_op("div_off", 4'b1011, 8'd100, 8'd7, 1);
        check_res("div_off", 8'h00, 8'h00, 1'b0, 1'b1);
`endif

        // Start and operand changes while busy are ignored
        @(negedge clk);
        control = 4'b0000; dataA = 8'd200; dataB = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        control = 4'b0010; dataA = 8'h11; dataB = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                check_res("busy_ign", 8'h58, 8'h02, 1'b0, 1'b0);
            end
        end
        check("busy_ign_dones", 64'(dcount), 64'd1);

        // Reset aborts an in-flight MUL; the ADD start at cycle 3 is ignored
        @(negedge clk);
        control = 4'b0000; dataA = 8'd200; dataB = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        control = 4'b0010; dataA = 8'hFF; dataB = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check_res("abort", 8'h00, 8'h00, 1'b0, 1'b1);
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'd0);

        // Back-to-back: second op issued in the IDLE cycle right after DONE
        do_op("b2b_1", 4'b0111, 8'h3C, 8'hFF, 1);
        check_res("b2b_1", 8'hC3, 8'h00, 1'b0, 1'b0);
        do_op("b2b_2", 4'b0010, 8'h10, 8'h20, 1);
        check_res("b2b_2", 8'h30, 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WORD_LENGTH, 32, operand/result width in bits (legal 8..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request pulse; operands and opcode sampled when start=1 in IDLE.
REQ-005 control  input  4  opcode.
REQ-006 dataA  input  WORD_LENGTH  first operand.
REQ-007 dataB  input  WORD_LENGTH  second operand.
REQ-008 busy  output  1  high while an operation is in progress (not IDLE).
REQ-009 done  output  1  one-cycle pulse when results become valid.
REQ-010 dataC  output  WORD_LENGTH  primary result (low product word / quotient).
REQ-011 dataHi  output  WORD_LENGTH  secondary result (high product word / remainder); zero for other ops.
REQ-012 carry  output  1  carry/borrow/divide-by-zero flag.
REQ-013 zero  output  1  high when dataC == 0, updated with done.

Function
REQ-014 Opcodes: 0000 MUL, 0001 SUB, 0010 ADD, 0011 NOT A, 0100 two's complement A, 0101 AND, 0110 OR, 0111 XOR, 1000 A<<B, 1001 A>>B (logical), 1010 (B<<2)+4, 1011 DIV (unsigned); others: result 0, carry 0.
REQ-015 FSM states IDLE, CALC, DONE; reset enters IDLE.
REQ-016 IDLE: start=1 latches dataA, dataB, control; MUL/DIV -> CALC, all other opcodes -> DONE.
REQ-017 CALC: one iteration per cycle, exactly WORD_LENGTH cycles (iteration counter), then -> DONE.
REQ-018 DONE: results registered, done=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-019 Latency from start sample edge to done: 1 cycle for single-cycle ops, WORD_LENGTH+1 cycles for MUL/DIV.
REQ-020 start while busy=1 (CALC or DONE) is ignored; no queueing; operand changes during CALC have no effect.
REQ-021 dataC, dataHi, carry, zero hold their values from the last done until the next done.
REQ-022 MUL: shift-add, unsigned; full 2*WORD_LENGTH product split dataHi:dataC; carry=0.
REQ-023 ADD: carry = bit WORD_LENGTH of the (WORD_LENGTH+1)-bit sum; dataC = sum modulo 2^WORD_LENGTH.
REQ-024 SUB: dataC = |A-B| (magnitude); carry=1 iff A<B; A==B gives dataC=0, carry=0.
REQ-025 Shifts: shift amount is the full dataB value; amount >= WORD_LENGTH yields 0; carry=0.
REQ-026 Opcode 1010: carry = bit WORD_LENGTH of (B<<2)+4 computed at WORD_LENGTH+1 bits, B<<2 truncated to WORD_LENGTH first.
REQ-027 DIV: restoring division, unsigned; dataC=quotient, dataHi=remainder, carry=0.
REQ-028 DIV by zero: dataC = all ones, dataHi = dataA, carry=1; still takes WORD_LENGTH+1 cycles.

Reset
REQ-029 reset=0 at a clock edge forces IDLE, busy=0, done=0, dataC=0, dataHi=0, carry=0, zero=1, counter=0.
REQ-030 Reset during CALC or DONE aborts the operation; no done pulse is produced for it.
REQ-031 reset has priority over start on the same edge.

Configuration
REQ-032 Macro ALU_DIV_EN: defined -> opcode 1011 performs DIV per REQ-027/028 with iterative datapath compiled in.
REQ-033 ALU_DIV_EN undefined -> no divider logic; 1011 treated as undefined opcode (IDLE -> DONE, dataC=0, dataHi=0, carry=0, zero=1, latency 1).

Verification (WORD_LENGTH=8)
REQ-034 MUL A=200, B=3, start 1 cycle -> busy 9 cycles, done at cycle 9, dataC=0x58, dataHi=0x02, carry=0.
REQ-035 ADD A=0xFF, B=0x01 -> done after 1 cycle, dataC=0x00, carry=1, zero=1; SUB A=3, B=5 -> dataC=2, carry=1.
REQ-036 DIV A=100, B=7 (ALU_DIV_EN) -> done at cycle 9, dataC=14, dataHi=2; B=0 -> dataC=0xFF, dataHi=100, carry=1.
REQ-037 Start MUL, pulse start with ADD at cycle 3, assert reset=0 at cycle 5 -> ADD ignored, no done, all outputs at reset values, busy=0 next cycle.
REQ-038 SHL A=0x81, B=1 -> dataC=0x02; SHL B=8 -> dataC=0; opcode 1111 -> dataC=0, carry=0, done after 1 cycle.
REQ-039 Back-to-back: start in IDLE immediately after DONE -> accepted; results held unchanged between done pulses.
